// File: rtl/bram_arbiter_2p.sv
// Round-robin arbiter letting two requesters share one single-port BRAM.
// One op per cycle; reads return to their source two cycles after accept.
module bram_arbiter_2p #(
    parameter int data_width = 32,
    parameter int addr_width = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [addr_width-1:0] a_req_addr,
    input  logic [data_width-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [data_width-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [addr_width-1:0] b_req_addr,
    input  logic [data_width-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [data_width-1:0] b_rsp_rdata,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_din,
    input  logic [data_width-1:0] mem_dout
);

    typedef enum logic {SIDE_A, SIDE_B} side_t;

    side_t ptr, ptr_next;
    logic  grant_a, grant_b, accept;

    logic                  sel_we;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_wdata;

    logic  iss_valid, iss_read;
    side_t iss_src;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_req_valid && (!b_req_valid || ptr == SIDE_A))
                grant_a = 1'b1;
            else if (b_req_valid)
                grant_b = 1'b1;
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign accept      = grant_a | grant_b;

    always_comb begin
        ptr_next = ptr;
        if (grant_a)
            ptr_next = SIDE_B;
        else if (grant_b)
            ptr_next = SIDE_A;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= SIDE_A;
        else
            ptr <= ptr_next;
    end

    always_comb begin
        sel_we    = a_req_we;
        sel_addr  = a_req_addr;
        sel_wdata = a_req_wdata;
        if (grant_b) begin
            sel_we    = b_req_we;
            sel_addr  = b_req_addr;
            sel_wdata = b_req_wdata;
        end
    end

    // Idle cycles keep mem_addr; a stray read of it is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            iss_valid <= 1'b0;
            iss_read  <= 1'b0;
            iss_src   <= SIDE_A;
        end else begin
            mem_we    <= accept & sel_we;
            iss_valid <= accept;
            if (accept) begin
                mem_addr <= sel_addr;
                mem_din  <= sel_wdata;
                iss_read <= ~sel_we;
                iss_src  <= grant_b ? SIDE_B : SIDE_A;
            end
        end
    end

    // Response tag lines up with the BRAM's registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
        end else begin
            a_rsp_valid <= iss_valid & iss_read & (iss_src == SIDE_A);
            b_rsp_valid <= iss_valid & iss_read & (iss_src == SIDE_B);
        end
    end

    assign a_rsp_rdata = mem_dout;
    assign b_rsp_rdata = mem_dout;

endmodule
